// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mul_sequencer                                            |
// | Description : Iterative 32x32 unsigned multiplier (low word of product).   |
// |               Borrows the shared EXE-stage ALU for its add and shift       |
// |               steps, one multiplier bit per iteration.                     |
// |               Optional macro MUL_EARLY_EXIT_EN: stop once the remaining    |
// |               multiplier bits are all zero (op_b==0 finishes at once).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif
`ifndef EXE_ADD
`define EXE_ADD 4'd0
`endif
`ifndef EXE_SLL
`define EXE_SLL 4'd7
`endif

module alu_mul_sequencer #(
  parameter int WORD_LEN    = `WORD_LEN,
  parameter int EXE_CMD_LEN = `EXE_CMD_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_LEN-1:0]    op_a,
  input  logic [WORD_LEN-1:0]    op_b,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LEN-1:0]    result,
  output logic                   alu_req,
  output logic [WORD_LEN-1:0]    alu_val1,
  output logic [WORD_LEN-1:0]    alu_val2,
  output logic [EXE_CMD_LEN-1:0] alu_cmd,
  input  logic [WORD_LEN-1:0]    alu_out
);

  localparam logic [WORD_LEN-1:0]    c_one   = WORD_LEN'(1);
  localparam logic [EXE_CMD_LEN-1:0] c_cmd_add = EXE_CMD_LEN'(`EXE_ADD);
  localparam logic [EXE_CMD_LEN-1:0] c_cmd_sll = EXE_CMD_LEN'(`EXE_SLL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [WORD_LEN-1:0] r_acc;
  logic [WORD_LEN-1:0] r_mcand;
  logic [WORD_LEN-1:0] r_mplier;
  logic [5:0]          r_cnt;

  // w_last: the SHIFT in progress is the final iteration.
  // w_skip: an accepted start needs no ALU cycles at all.
  logic w_last;
  logic w_skip;

`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == 6'd31) || ((r_mplier >> 1) == '0);
  assign w_skip = (op_b == '0);
`else
  assign w_last = (r_cnt == 6'd31);
  assign w_skip = 1'b0;
`endif

  // Sequencer FSM; every output is registered and set up for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      alu_req  <= 1'b0;
      alu_val1 <= '0;
      alu_val2 <= '0;
      alu_cmd  <= c_cmd_add;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_cnt    <= '0;
            if (w_skip) begin
              // Zero multiplier: product is zero, report it immediately.
              r_state <= S_DONE;
              done    <= 1'b1;
              result  <= '0;
            end else if (op_b[0]) begin
              r_state  <= S_ADD;
              busy     <= 1'b1;
              alu_req  <= 1'b1;
              alu_val1 <= '0;
              alu_val2 <= op_a;
              alu_cmd  <= c_cmd_add;
            end else begin
              r_state  <= S_SHIFT;
              busy     <= 1'b1;
              alu_req  <= 1'b1;
              alu_val1 <= op_a;
              alu_val2 <= c_one;
              alu_cmd  <= c_cmd_sll;
            end
          end
        end

        S_ADD: begin
          // acc + mcand comes back from the ALU; shift mcand next.
          r_acc    <= alu_out;
          r_state  <= S_SHIFT;
          alu_val1 <= r_mcand;
          alu_val2 <= c_one;
          alu_cmd  <= c_cmd_sll;
        end

        S_SHIFT: begin
          r_mcand  <= alu_out;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
          if (w_last) begin
            // acc is stable through SHIFT, so it is already the final product.
            r_state  <= S_DONE;
            result   <= r_acc;
            done     <= 1'b1;
            busy     <= 1'b0;
            alu_req  <= 1'b0;
            alu_val1 <= '0;
            alu_val2 <= '0;
            alu_cmd  <= c_cmd_add;
          end else if (r_mplier[1]) begin
            // Next bit set: add the freshly shifted multiplicand.
            r_state  <= S_ADD;
            alu_val1 <= r_acc;
            alu_val2 <= alu_out;
            alu_cmd  <= c_cmd_add;
          end else begin
            r_state  <= S_SHIFT;
            alu_val1 <= alu_out;
            alu_val2 <= c_one;
            alu_cmd  <= c_cmd_sll;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

- Iterative 32x32 unsigned multiplier; produces the low 32 bits of the product.
- Owns no adder or shifter of its own: it drives the shared EXE-stage ALU with `EXE_ADD` and `EXE_SLL` commands, one bit of the multiplier per iteration.
- Sits beside the EXE stage. While `alu_req` is high, the EXE input mux routes `alu_val1`/`alu_val2`/`alu_cmd` to the ALU, and the hazard unit stalls the pipeline on `busy`.

## Interface
Parameters:
- WORD_LEN, `WORD_LEN (32): operand/result width
- EXE_CMD_LEN, `EXE_CMD_LEN: ALU command width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op_a  in  WORD_LEN  multiplicand, latched on accepted start
- op_b  in  WORD_LEN  multiplier, latched on accepted start
- busy  out  1  high in ADD and SHIFT
- done  out  1  one-cycle pulse in DONE
- result  out  WORD_LEN  product low word, held until next DONE
- alu_req  out  1  sequencer owns the ALU (ADD or SHIFT)
- alu_val1  out  WORD_LEN  ALU operand 1
- alu_val2  out  WORD_LEN  ALU operand 2
- alu_cmd  out  EXE_CMD_LEN  ALU command
- alu_out  in  WORD_LEN  combinational ALU result, same cycle

## Operation
- Internal registers: acc, mcand, mplier (all WORD_LEN), cnt (6 bits), state.
- States: IDLE, ADD, SHIFT, DONE.
- **IDLE**
  - On start: acc←0, mcand←op_a, mplier←op_b, cnt←0.
  - Next state: ADD if op_b[0], else SHIFT.
  - start=0: remain in IDLE.
- **ADD**
  - Drives alu_val1=acc, alu_val2=mcand, alu_cmd=`EXE_ADD`.
  - acc←alu_out; next state SHIFT.
- **SHIFT**
  - Drives alu_val1=mcand, alu_val2=1, alu_cmd=`EXE_SLL`.
  - mcand←alu_out, mplier←mplier>>1, cnt←cnt+1.
  - Next state DONE if cnt==31 (or the early-exit condition, see Configuration). Otherwise ADD if mplier[1], else SHIFT.
- **DONE**
  - result←acc, done=1; next state IDLE unconditionally.
- Arithmetic is modulo 2^32. Carries out of acc and bits shifted out of mcand are discarded.
- Outside ADD/SHIFT the ALU outputs are forced to alu_val1=0, alu_val2=0, alu_cmd=`EXE_ADD`, alu_req=0.
- start is ignored in ADD, SHIFT and DONE; there is no queueing. op_a/op_b changes after acceptance have no effect.

## Timing
- Reset values: state IDLE; busy=0, done=0, result=0, alu_req=0, alu_val1=0, alu_val2=0, alu_cmd=`EXE_ADD`; acc/mcand/mplier/cnt=0.
- Reset asserted mid-operation aborts immediately. Outputs take their reset values, and the first start after deassertion is accepted normally.
- Start accepted at edge T: the first ADD/SHIFT cycle is T+1.
- Without early exit, latency = 32 SHIFT cycles + popcount(op_b) ADD cycles. done is high in cycle T+33+popcount(op_b), and result is valid from the same cycle.
- busy and alu_req are registered from state. They go high the cycle after start is accepted, and are low in DONE and IDLE.
- A start in the cycle after DONE (IDLE) is accepted, so back-to-back operations have a 1-cycle gap.

## Configuration
- `MUL_EARLY_EXIT_EN`
  - Defined: SHIFT goes to DONE when cnt==31 or (mplier>>1)==0. In IDLE, start with op_b==0 goes straight to DONE (acc=0, no ALU cycles).
  - Undefined: always exactly 32 SHIFT iterations; op_b==0 takes the full 32 cycles.
- Results are identical either way; only latency differs.

## Test plan
- Reset, then op_a=3, op_b=5, start at T → result=15. done at T+35 (no EXIT_EN) or T+6 (EXIT_EN). alu_cmd sequence starts ADD, SHIFT, SHIFT.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → result=0x00000001, done at T+65 in both builds. busy high for exactly 64 cycles.
- op_a=0x12345678, op_b=0 → result=0. done at T+33 (no EXIT_EN) or T+1 (EXIT_EN, alu_req never high).
- start held high continuously with op_a=2, op_b=7 → one operation only during busy. result=14. A new start is accepted the cycle after done.
- op_a=0x80000000, op_b=2 → result=0 (overflow discarded). Then assert rst mid-run at cycle T+10 → all outputs 0 and state IDLE immediately. A next start with 6×7 gives 42.
